lsb_queue_v2: RTL and testbench

- Parametrised in-order load/store queue between issue/ROB and the memory controller.
- Depth and the number of result-broadcast (CDB) channels are generic.
- Stores commit by ROB tag, not by queue index.
- Flush keeps already-committed stores.
- Loads to I/O space are held until they are non-speculative.

---
 rtl/lsb_queue_v2.sv | 232 +++++++++++++++++++++++
 tb/tb_lsb_queue_v2.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_queue_v2.sv
// lsb_queue_v2: in-order load/store queue between issue/ROB and memory.
// Stores issue only after ROB commit; I/O loads wait for the ROB head.
module lsb_queue_v2 #(
    parameter int          DEPTH   = 16,
    parameter int          IDX_W   = 4,
    parameter int          ROB_W   = 4,
    parameter int          NCDB    = 2,
    parameter logic [31:0] IO_BASE = 32'h00030000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  push_store,
    input  logic [2:0]            push_funct3,
    input  logic [31:0]           push_imm,
    input  logic [ROB_W-1:0]      push_robpos,
    input  logic [31:0]           push_vj,
    input  logic [31:0]           push_vk,
    input  logic                  push_qj,
    input  logic                  push_qk,
    output logic                  lsb_full,
    output logic [IDX_W:0]        lsb_count,
    input  logic [NCDB-1:0]       cdb_valid,
    input  logic [NCDB*ROB_W-1:0] cdb_robpos,
    input  logic [NCDB*32-1:0]    cdb_val,
    input  logic                  commit_store,
    input  logic [ROB_W-1:0]      commit_robpos,
    input  logic [ROB_W-1:0]      rob_head_robpos,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [1:0]            mem_len,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_done,
    input  logic [31:0]           mem_rdata,
    output logic                  ld_valid,
    output logic [31:0]           ld_val,
    output logic [ROB_W-1:0]      ld_robpos
);
    localparam int CW = IDX_W + 1;

    typedef enum logic {IDLE, WAIT_MEM} state_t;
    state_t state, state_nx;

    logic [DEPTH-1:0] e_valid, e_store, e_cmt, e_qj, e_qk;
    logic [2:0]       e_f3  [DEPTH];
    logic [31:0]      e_imm [DEPTH];
    logic [31:0]      e_vj  [DEPTH];
    logic [31:0]      e_vk  [DEPTH];
    logic [ROB_W-1:0] e_rob [DEPTH];

    logic [IDX_W-1:0] head, tail, nhead;
    logic [CW-1:0]    count, kept;
    logic [DEPTH-1:0] keep;
    logic             stale;
    logic [2:0]       m_f3;
    logic [ROB_W-1:0] m_rob;
    logic [31:0]      h_addr, ext;
    logic             h_ok, go, push_ok, retire, drop_ld;
    logic [32:0]      wj [DEPTH];
    logic [32:0]      wk [DEPTH];
    logic [32:0]      pj, pk;

    // Scanning high to low lets the lowest matching channel win.
    function automatic logic [32:0] cdb_hit(
        input logic [ROB_W-1:0]      tag,
        input logic [NCDB-1:0]       v,
        input logic [NCDB*ROB_W-1:0] r,
        input logic [NCDB*32-1:0]    d
    );
        logic [32:0] h;
        h = '0;
        for (int c = NCDB - 1; c >= 0; c--)
            if (v[c] && r[c*ROB_W +: ROB_W] == tag)
                h = {1'b1, d[c*32 +: 32]};
        return h;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wj[i] = cdb_hit(e_vj[i][ROB_W-1:0], cdb_valid, cdb_robpos, cdb_val);
            wk[i] = cdb_hit(e_vk[i][ROB_W-1:0], cdb_valid, cdb_robpos, cdb_val);
        end
        pj = cdb_hit(push_vj[ROB_W-1:0], cdb_valid, cdb_robpos, cdb_val);
        pk = cdb_hit(push_vk[ROB_W-1:0], cdb_valid, cdb_robpos, cdb_val);
    end

    always_comb begin
        h_addr  = e_vj[head] + e_imm[head];
        h_ok    = e_store[head] ? e_cmt[head]
                : (h_addr < IO_BASE || e_rob[head] == rob_head_robpos);
        go      = state == IDLE && e_valid[head] && !e_qj[head]
                && !e_qk[head] && h_ok && !stale && !clear;
        push_ok = push && !lsb_full && !clear;
        retire  = state == WAIT_MEM && mem_done;
        drop_ld = clear && state == WAIT_MEM && !mem_we && !mem_done;
        nhead   = head + IDX_W'(retire || drop_ld);
        kept    = '0;
        // Committed stores (including one committing this cycle) survive a flush.
        for (int i = 0; i < DEPTH; i++) begin
            keep[i] = e_valid[i] && e_store[i]
                    && (e_cmt[i] || (commit_store && e_rob[i] == commit_robpos))
                    && !(retire && head == IDX_W'(i));
            kept = kept + CW'(keep[i]);
        end
    end

    always_comb begin
        unique case (1'b1)
            m_f3 == 3'b000: ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            m_f3 == 3'b001: ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            m_f3 == 3'b100: ext = {24'h0, mem_rdata[7:0]};
            m_f3 == 3'b101: ext = {16'h0, mem_rdata[15:0]};
            default:        ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else if (ready) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (go) state_nx = WAIT_MEM;
            WAIT_MEM: if (mem_done || drop_ld) state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == WAIT_MEM);
    end

    assign lsb_full  = count >= CW'(DEPTH - 1);
    assign lsb_count = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
            e_store <= '0;
            e_cmt   <= '0;
            e_qj    <= '0;
            e_qk    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_f3[i]  <= '0;
                e_imm[i] <= '0;
                e_vj[i]  <= '0;
                e_vk[i]  <= '0;
                e_rob[i] <= '0;
            end
        end else if (ready) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_qj[i] && wj[i][32]) begin
                    e_vj[i] <= wj[i][31:0];
                    e_qj[i] <= 1'b0;
                end
                if (e_qk[i] && wk[i][32]) begin
                    e_vk[i] <= wk[i][31:0];
                    e_qk[i] <= 1'b0;
                end
                if (commit_store && e_valid[i] && e_store[i]
                    && e_rob[i] == commit_robpos)
                    e_cmt[i] <= 1'b1;
            end
            if (push_ok) begin
                e_valid[tail] <= 1'b1;
                e_store[tail] <= push_store;
                e_cmt[tail]   <= 1'b0;
                e_f3[tail]    <= push_funct3;
                e_imm[tail]   <= push_imm;
                e_rob[tail]   <= push_robpos;
                e_vj[tail]    <= (push_qj && pj[32]) ? pj[31:0] : push_vj;
                e_vk[tail]    <= (push_qk && pk[32]) ? pk[31:0] : push_vk;
                e_qj[tail]    <= push_qj && !pj[32];
                e_qk[tail]    <= push_qk && !pk[32];
            end
            if (clear) begin
                e_valid <= keep;
                e_cmt   <= keep;
                head    <= nhead;
                tail    <= nhead + kept[IDX_W-1:0];
                count   <= kept;
            end else begin
                if (retire) begin
                    e_valid[head] <= 1'b0;
                    e_cmt[head]   <= 1'b0;
                    head          <= head + 1'b1;
                end
                if (push_ok) tail <= tail + 1'b1;
                count <= count + CW'(push_ok) - CW'(retire);
            end
        end
    end

    // A flushed in-flight load leaves the bus stale until its done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_len   <= '0;
            mem_wdata <= '0;
            m_f3      <= '0;
            m_rob     <= '0;
            ld_valid  <= 1'b0;
            ld_val    <= '0;
            ld_robpos <= '0;
            stale     <= 1'b0;
        end else if (ready) begin
            ld_valid <= retire && !mem_we && !clear;
            if (go) begin
                mem_we    <= e_store[head];
                mem_addr  <= h_addr;
                mem_len   <= {e_f3[head][1], |e_f3[head][1:0]};
                mem_wdata <= e_vk[head];
                m_f3      <= e_f3[head];
                m_rob     <= e_rob[head];
            end
            if (retire && !mem_we) begin
                ld_val    <= ext;
                ld_robpos <= m_rob;
            end
            if (drop_ld) stale <= 1'b1;
            else if (state == IDLE && mem_done) stale <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lsb_queue_v2.sv
// tb_lsb_queue_v2: directed scoreboard bench for lsb_queue_v2.
// Expected requests and load results are queued at stimulus time.
module tb_lsb_queue_v2;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;
    localparam int ROB_W = 4;
    localparam int NCDB  = 2;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ready, clear, push, push_store, push_qj, push_qk;
    logic [2:0]  push_funct3;
    logic [31:0] push_imm, push_vj, push_vk;
    logic [3:0]  push_robpos, commit_robpos, rob_head_robpos;
    logic        lsb_full;
    logic [4:0]  lsb_count;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_robpos;
    logic [63:0] cdb_val;
    logic        commit_store, mem_req, mem_we, mem_done, ld_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, ld_val;
    logic [1:0]  mem_len;
    logic [3:0]  ld_robpos;

    lsb_queue_v2 #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .ROB_W(ROB_W), .NCDB(NCDB),
        .IO_BASE(32'h00030000)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready), .clear(clear),
        .push(push), .push_store(push_store), .push_funct3(push_funct3),
        .push_imm(push_imm), .push_robpos(push_robpos),
        .push_vj(push_vj), .push_vk(push_vk),
        .push_qj(push_qj), .push_qk(push_qk),
        .lsb_full(lsb_full), .lsb_count(lsb_count),
        .cdb_valid(cdb_valid), .cdb_robpos(cdb_robpos), .cdb_val(cdb_val),
        .commit_store(commit_store), .commit_robpos(commit_robpos),
        .rob_head_robpos(rob_head_robpos),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_len(mem_len), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_val(ld_val), .ld_robpos(ld_robpos)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wd;
    } req_t;
    typedef struct {
        logic [31:0] val;
        logic [3:0]  rob;
    } ld_t;

    req_t exp_req[$];
    ld_t  exp_ld[$];
    int checks = 0;
    int errors = 0;
    logic        mem_auto = 1'b1;
    logic [31:0] rdata_next = '0;
    int          wait_cnt = 0;
    logic        prev_req = 1'b0, prev_ld = 1'b0, done_last = 1'b0;
    logic [31:0] prev_addr = '0, prev_wd = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        req_t r;
        ld_t  l;
        @(posedge clk);
        #1;
        mem_done = 1'b0;
        if (ld_valid) begin
            chk("ld_single_cycle", 32'(prev_ld), 32'd0);
            checks++;
            assert (exp_ld.size() > 0) else begin
                errors++;
                $error("FAIL ld_unexpected observed rob %0d expected none", ld_robpos);
            end
            if (exp_ld.size() > 0) begin
                l = exp_ld.pop_front();
                chk("ld_val", ld_val, l.val);
                chk("ld_robpos", 32'(ld_robpos), 32'(l.rob));
            end
        end
        if (done_last) chk("idle_gap", 32'(mem_req), 32'd0);
        if (mem_req && !prev_req) begin
            checks++;
            assert (exp_req.size() > 0) else begin
                errors++;
                $error("FAIL req_unexpected observed addr %h expected none", mem_addr);
            end
            if (exp_req.size() > 0) begin
                r = exp_req.pop_front();
                chk("mem_we", 32'(mem_we), 32'(r.we));
                chk("mem_addr", mem_addr, r.addr);
                chk("mem_len", 32'(mem_len), 32'(r.len));
                if (r.we) chk("mem_wdata", mem_wdata, r.wd);
            end
        end
        if (mem_req && prev_req) begin
            chk("hold_addr", mem_addr, prev_addr);
            chk("hold_wdata", mem_wdata, prev_wd);
        end
        done_last = 1'b0;
        if (mem_auto && mem_req) begin
            wait_cnt++;
            if (wait_cnt == LAT) begin
                mem_done   = 1'b1;
                mem_rdata  = rdata_next;
                done_last  = 1'b1;
                wait_cnt   = 0;
            end
        end else begin
            wait_cnt = 0;
        end
        prev_req  = mem_req;
        prev_ld   = ld_valid;
        prev_addr = mem_addr;
        prev_wd   = mem_wdata;
    endtask

    task automatic do_push(input logic st, input logic [2:0] f3,
                           input logic [31:0] imm, input logic [3:0] rob,
                           input logic [31:0] vj, input logic [31:0] vk,
                           input logic qj);
        push        = 1'b1;
        push_store  = st;
        push_funct3 = f3;
        push_imm    = imm;
        push_robpos = rob;
        push_vj     = vj;
        push_vk     = vk;
        push_qj     = qj;
        push_qk     = 1'b0;
        step();
        push    = 1'b0;
        push_qj = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (!mem_req && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_req.size() > 0 || exp_ld.size() > 0 || lsb_count != 0)
               && n < budget) begin
            step();
            n++;
        end
        step();
        chk({tag, "_req_left"}, 32'(exp_req.size()), 32'd0);
        chk({tag, "_ld_left"}, 32'(exp_ld.size()), 32'd0);
        chk({tag, "_count"}, 32'(lsb_count), 32'd0);
    endtask

    initial begin
        reset = 1'b0; ready = 1'b1; clear = 1'b0; push = 1'b0;
        push_store = 1'b0; push_qj = 1'b0; push_qk = 1'b0;
        push_funct3 = '0; push_imm = '0; push_vj = '0; push_vk = '0;
        push_robpos = '0; commit_store = 1'b0; commit_robpos = '0;
        rob_head_robpos = '0; cdb_valid = '0; cdb_robpos = '0;
        cdb_val = '0; mem_done = 1'b0; mem_rdata = '0;
        step();
        step();
        chk("rst_count", 32'(lsb_count), 32'd0);
        chk("rst_full", 32'(lsb_full), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_ldv", 32'(ld_valid), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        reset = 1'b1;
        step();

        exp_req.push_back('{1'b0, 32'h1004, 2'b11, 32'h0});
        exp_ld.push_back('{32'h800000FF, 4'd1});
        rdata_next = 32'h800000FF;
        do_push(1'b0, 3'b010, 32'd4, 4'd1, 32'h1000, 32'h0, 1'b0);
        drain("t1_lw", 30);

        ready = 1'b0;
        do_push(1'b0, 3'b010, 32'd0, 4'd2, 32'h100, 32'h0, 1'b0);
        chk("frozen_count", 32'(lsb_count), 32'd0);
        ready = 1'b1;

        do_push(1'b0, 3'b000, 32'h10, 4'd2, 32'd5, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("lb_wait_wake", 32'(mem_req), 32'd0);
        end
        exp_req.push_back('{1'b0, 32'h2010, 2'b00, 32'h0});
        exp_ld.push_back('{32'hFFFFFF80, 4'd2});
        rdata_next = 32'hABCDEF80;
        cdb_valid  = 2'b11;
        cdb_robpos = {4'd5, 4'd7};
        cdb_val    = {32'h2000, 32'hBAD00000};
        step();
        cdb_valid = '0;
        drain("t2_lb", 30);

        do_push(1'b0, 3'b100, 32'h20, 4'd3, 32'd6, 32'h0, 1'b1);
        step();
        exp_req.push_back('{1'b0, 32'h3020, 2'b00, 32'h0});
        exp_ld.push_back('{32'h00000080, 4'd3});
        cdb_valid  = 2'b11;
        cdb_robpos = {4'd6, 4'd6};
        cdb_val    = {32'h4000, 32'h3000};
        step();
        cdb_valid = '0;
        drain("t2_lbu", 30);

        exp_req.push_back('{1'b0, 32'h5002, 2'b01, 32'h0});
        exp_ld.push_back('{32'hFFFF8001, 4'd4});
        rdata_next = 32'h00008001;
        cdb_valid  = 2'b01;
        cdb_robpos = {4'd0, 4'd9};
        cdb_val    = {32'h0, 32'h5000};
        do_push(1'b0, 3'b001, 32'd2, 4'd4, 32'd9, 32'h0, 1'b1);
        cdb_valid = '0;
        drain("t2_lh_bypass", 30);

        exp_req.push_back('{1'b1, 32'h100, 2'b11, 32'hDEADBEEF});
        exp_req.push_back('{1'b0, 32'h208, 2'b11, 32'h0});
        exp_ld.push_back('{32'h11223344, 4'd4});
        rdata_next = 32'h11223344;
        do_push(1'b1, 3'b010, 32'd0, 4'd3, 32'h100, 32'hDEADBEEF, 1'b0);
        do_push(1'b0, 3'b010, 32'd8, 4'd4, 32'h200, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("st_wait_commit", 32'(mem_req), 32'd0);
        end
        commit_store  = 1'b1;
        commit_robpos = 4'd3;
        step();
        commit_store = 1'b0;
        drain("t3_st_ld", 40);

        mem_auto = 1'b0;
        exp_req.push_back('{1'b0, 32'h400, 2'b11, 32'h0});
        do_push(1'b0, 3'b010, 32'd0, 4'd8, 32'h400, 32'h0, 1'b0);
        do_push(1'b1, 3'b010, 32'd0, 4'd9, 32'h500, 32'hAAAA0001, 1'b0);
        do_push(1'b1, 3'b010, 32'd0, 4'd10, 32'h504, 32'hAAAA0002, 1'b0);
        do_push(1'b0, 3'b010, 32'd0, 4'd11, 32'd15, 32'h0, 1'b1);
        do_push(1'b0, 3'b010, 32'd0, 4'd12, 32'd14, 32'h0, 1'b1);
        commit_store  = 1'b1;
        commit_robpos = 4'd9;
        step();
        commit_robpos = 4'd10;
        step();
        commit_store = 1'b0;
        wait_req("flush_ld_issued", 10);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("flush_count", 32'(lsb_count), 32'd2);
        chk("flush_req_drop", 32'(mem_req), 32'd0);
        step();
        step();
        mem_done  = 1'b1;
        done_last = 1'b1;
        step();
        exp_req.push_back('{1'b1, 32'h500, 2'b11, 32'hAAAA0001});
        exp_req.push_back('{1'b1, 32'h504, 2'b11, 32'hAAAA0002});
        mem_auto = 1'b1;
        drain("t4_flush", 60);

        rob_head_robpos = 4'd0;
        exp_req.push_back('{1'b0, 32'h2FFFC, 2'b11, 32'h0});
        exp_ld.push_back('{32'h000055AA, 4'd14});
        rdata_next = 32'h000055AA;
        do_push(1'b0, 3'b010, 32'd4, 4'd14, 32'h2FFF8, 32'h0, 1'b0);
        drain("t5_below_io", 30);
        do_push(1'b0, 3'b010, 32'd4, 4'd13, 32'h30000, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("io_spec_hold", 32'(mem_req), 32'd0);
        end
        exp_req.push_back('{1'b0, 32'h30004, 2'b11, 32'h0});
        exp_ld.push_back('{32'h000055AA, 4'd13});
        rob_head_robpos = 4'd13;
        drain("t5_io", 30);

        for (int i = 0; i < 15; i++) begin
            do_push(1'b1, 3'b010, 32'd0, 4'(i), 32'h1000 + 32'(i * 4),
                    32'(i), 1'b0);
            if (i == 13) chk("fill_not_full", 32'(lsb_full), 32'd0);
        end
        chk("fill_count", 32'(lsb_count), 32'd15);
        chk("fill_full", 32'(lsb_full), 32'd1);
        do_push(1'b1, 3'b010, 32'd0, 4'd15, 32'h9000, 32'h0, 1'b0);
        chk("full_push_ignored", 32'(lsb_count), 32'd15);
        for (int i = 0; i < 15; i++) begin
            exp_req.push_back('{1'b1, 32'h1000 + 32'(i * 4), 2'b11, 32'(i)});
            commit_store  = 1'b1;
            commit_robpos = 4'(i);
            step();
        end
        commit_store = 1'b0;
        drain("t6_wrap", 300);

        mem_auto = 1'b0;
        exp_req.push_back('{1'b0, 32'h40, 2'b11, 32'h0});
        do_push(1'b0, 3'b010, 32'd0, 4'd1, 32'h40, 32'h0, 1'b0);
        wait_req("rst_mid_issued", 10);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_count", 32'(lsb_count), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_mid_left", 32'(exp_req.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
